// File: rtl/registro_write_arbiter.sv
// Round-robin write arbiter: one requester per arbitration drives D_BUS and a one-hot
// register enable for a single WRITE cycle, then the pointer advances past the winner.
`timescale 1ns/1ps
module registro_write_arbiter #(
    parameter int unsigned REGISTRO_WIDTH = 4,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned NUM_REGS       = 8,
    parameter int unsigned ADDR_WIDTH     = 3
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_REQ-1:0]                 REQ,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      REQ_ADDR,
    input  logic [NUM_REQ*REGISTRO_WIDTH-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]                 GNT,
    output logic [NUM_REGS-1:0]                EN_REG,
    output logic [REGISTRO_WIDTH-1:0]          D_BUS,
    output logic                               BUSY,
    output logic                               ERR
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [PTR_W-1:0]          r_ptr;
    logic [PTR_W-1:0]          r_idx;
    logic [NUM_REQ-1:0]        r_gnt;
    logic [NUM_REGS-1:0]       r_en;
    logic [REGISTRO_WIDTH-1:0] r_dbus;
    logic                      r_busy;
    logic                      r_err;

    logic [PTR_W-1:0]          w_ptr_nxt;
    logic [PTR_W-1:0]          w_idx_nxt;
    logic [NUM_REQ-1:0]        w_gnt_nxt;
    logic [NUM_REGS-1:0]       w_en_nxt;
    logic [REGISTRO_WIDTH-1:0] w_dbus_nxt;
    logic                      w_busy_nxt;
    logic                      w_err_nxt;

    logic                      w_found;
    logic [PTR_W-1:0]          w_win;
    logic [ADDR_WIDTH-1:0]     w_win_addr;
    logic [REGISTRO_WIDTH-1:0] w_win_data;

    logic [ADDR_WIDTH-1:0]     w_req_addr [NUM_REQ];
    logic [REGISTRO_WIDTH-1:0] w_req_data [NUM_REQ];

    // (base + off) mod NUM_REQ, valid for non power-of-two NUM_REQ as well
    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] base,
                                                  input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_addr[g] = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_req_data[g] = REQ_DATA[g*REGISTRO_WIDTH +: REGISTRO_WIDTH];
    end

    // First set REQ bit searching from r_ptr upwards with wrap
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && REQ[rr_slot(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_slot(r_ptr, k);
            end
        end
    end

    assign w_win_addr = w_req_addr[w_win];
    assign w_win_data = w_req_data[w_win];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the next cycle; the WRITE-cycle outputs are computed on entry
    always_comb begin
        w_ptr_nxt  = r_ptr;
        w_idx_nxt  = r_idx;
        w_gnt_nxt  = '0;
        w_en_nxt   = '0;
        w_dbus_nxt = r_dbus;
        w_busy_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_idx_nxt  = w_win;
                    w_gnt_nxt  = NUM_REQ'(1) << w_win;
                    w_dbus_nxt = w_win_data;
                    w_busy_nxt = 1'b1;
                    if (32'(w_win_addr) < NUM_REGS) w_en_nxt  = NUM_REGS'(1) << w_win_addr;
                    else                            w_err_nxt = 1'b1;
                end
            end
            S_WRITE: w_ptr_nxt = rr_slot(r_idx, 1);
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr  <= '0;
            r_idx  <= '0;
            r_gnt  <= '0;
            r_en   <= '0;
            r_dbus <= '0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_ptr  <= w_ptr_nxt;
            r_idx  <= w_idx_nxt;
            r_gnt  <= w_gnt_nxt;
            r_en   <= w_en_nxt;
            r_dbus <= w_dbus_nxt;
            r_busy <= w_busy_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign GNT    = r_gnt;
    assign EN_REG = r_en;
    assign D_BUS  = r_dbus;
    assign BUSY   = r_busy;
    assign ERR    = r_err;

endmodule

// File: tb/tb_registro_write_arbiter.sv
// Bench for registro_write_arbiter: directed scenarios then random registered requesters,
// compared against a spec-level round-robin model; two DUTs share inputs (8 and 6 registers).
`timescale 1ns/1ps
module tb_registro_write_arbiter;

    localparam int unsigned RW = 4;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 3;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NR-1:0]  REQ;
    logic [AW-1:0]  req_addr [NR];
    logic [RW-1:0]  req_data [NR];
    logic [NR*AW-1:0] REQ_ADDR;
    logic [NR*RW-1:0] REQ_DATA;

    logic [NR-1:0] gnt8, gnt6;
    logic [7:0]    en8;
    logic [5:0]    en6;
    logic [RW-1:0] dbus8, dbus6;
    logic          busy8, busy6, err8, err6;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign REQ_ADDR[g*AW +: AW] = req_addr[g];
        assign REQ_DATA[g*RW +: RW] = req_data[g];
    end

    registro_write_arbiter #(.REGISTRO_WIDTH(RW), .NUM_REQ(NR), .NUM_REGS(8), .ADDR_WIDTH(AW)) dut8 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .GNT(gnt8), .EN_REG(en8), .D_BUS(dbus8), .BUSY(busy8), .ERR(err8));

    registro_write_arbiter #(.REGISTRO_WIDTH(RW), .NUM_REQ(NR), .NUM_REGS(6), .ADDR_WIDTH(AW)) dut6 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .GNT(gnt6), .EN_REG(en6), .D_BUS(dbus6), .BUSY(busy6), .ERR(err6));

    always #5 CLK = ~CLK;

    // Register banks fed by each DUT's outputs
    logic [RW-1:0] bank8 [8];
    logic [RW-1:0] bank6 [6];
    always @(posedge CLK) begin
        for (int k = 0; k < 8; k++) if (en8[k]) bank8[k] <= dbus8;
        for (int k = 0; k < 6; k++) if (en6[k]) bank6[k] <= dbus6;
    end

    int checks = 0;
    int errors = 0;
    bit auto_req = 1'b0;

    // Reference model state
    int            m_ptr;
    bit            m_writing;
    int            m_idx;
    int            m_addr;
    logic [RW-1:0] m_data;
    logic [RW-1:0] mbank8 [8];
    logic [RW-1:0] mbank6 [6];
    logic [NR-1:0] exp_gnt;
    logic [7:0]    exp_en8;
    logic [5:0]    exp_en6;
    logic [RW-1:0] exp_dbus;
    logic          exp_busy, exp_err8, exp_err6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_writing = 1'b0; m_idx = 0;
        exp_gnt = '0; exp_en8 = '0; exp_en6 = '0; exp_dbus = '0;
        exp_busy = 1'b0; exp_err8 = 1'b0; exp_err6 = 1'b0;
    endtask

    // One clock edge of the arbiter as described by its rules
    task automatic model_edge();
        if (m_writing) begin
            if (m_addr < 8) mbank8[m_addr] = m_data;
            if (m_addr < 6) mbank6[m_addr] = m_data;
            m_ptr = (m_idx + 1) % NR;
            m_writing = 1'b0;
            exp_gnt = '0; exp_en8 = '0; exp_en6 = '0;
            exp_busy = 1'b0; exp_err8 = 1'b0; exp_err6 = 1'b0;
        end else if (REQ != '0) begin
            m_idx = -1;
            for (int k = 0; k < NR; k++)
                if (m_idx < 0 && REQ[(m_ptr + k) % NR]) m_idx = (m_ptr + k) % NR;
            m_addr = int'(req_addr[m_idx]);
            m_data = req_data[m_idx];
            exp_gnt = '0; exp_gnt[m_idx] = 1'b1;
            exp_en8 = '0; exp_en8[m_addr] = 1'b1;
            exp_err8 = 1'b0;
            exp_en6 = '0;
            if (m_addr < 6) exp_en6[m_addr] = 1'b1;
            exp_err6 = (m_addr >= 6);
            exp_dbus = m_data;
            exp_busy = 1'b1;
            m_writing = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("gnt8", 32'(gnt8), 32'(exp_gnt));
        chk("gnt6", 32'(gnt6), 32'(exp_gnt));
        chk("en8", 32'(en8), 32'(exp_en8));
        chk("en6", 32'(en6), 32'(exp_en6));
        chk("dbus8", 32'(dbus8), 32'(exp_dbus));
        chk("dbus6", 32'(dbus6), 32'(exp_dbus));
        chk("busy8", 32'(busy8), 32'(exp_busy));
        chk("busy6", 32'(busy6), 32'(exp_busy));
        chk("err8", 32'(err8), 32'(exp_err8));
        chk("err6", 32'(err6), 32'(exp_err6));
    endtask

    task automatic check_banks();
        for (int k = 0; k < 8; k++) chk($sformatf("bank8[%0d]", k), 32'(bank8[k]), 32'(mbank8[k]));
        for (int k = 0; k < 6; k++) chk($sformatf("bank6[%0d]", k), 32'(bank6[k]), 32'(mbank6[k]));
    endtask

    // Registered requesters: drop REQ at the edge GNT is seen, occasionally abandon or raise requests
    task automatic requesters(input logic [NR-1:0] prev);
        for (int i = 0; i < NR; i++) begin
            if (prev[i]) REQ[i] = 1'b0;
            else if (REQ[i]) begin
                if (!(m_writing && m_idx == i) && $urandom_range(0, 15) == 0) REQ[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                req_addr[i] = AW'($urandom_range(0, 7));
                req_data[i] = RW'($urandom);
                REQ[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        logic [NR-1:0] prev;
        prev = exp_gnt;
        @(posedge CLK);
        if (!RST) model_edge();
        #1;
        check_all();
        if (auto_req) requesters(prev);
    endtask

    initial begin
        logic [RW-1:0] keep;
        int order [5] = '{0, 1, 2, 3, 0};

        for (int k = 0; k < 8; k++) begin bank8[k] = '0; mbank8[k] = '0; end
        for (int k = 0; k < 6; k++) begin bank6[k] = '0; mbank6[k] = '0; end
        for (int i = 0; i < NR; i++) begin req_addr[i] = AW'(i); req_data[i] = RW'(i + 7); end

        // Reset held with all requests active
        RST = 1'b1; REQ = 4'b1111;
        model_reset();
        repeat (10) tick();
        chk("rst_busy", 32'(busy8), 32'h0);
        RST = 1'b0; REQ = '0;
        tick();

        // Single request to register 5
        REQ = 4'b0100; req_addr[2] = 3'd5; req_data[2] = 4'hA;
        tick();
        chk("t2_gnt", 32'(gnt8), 32'h4);
        chk("t2_en", 32'(en8), 32'h20);
        chk("t2_dbus", 32'(dbus8), 32'hA);
        tick();
        REQ = '0;
        chk("t2_bank5", 32'(bank8[5]), 32'hA);
        tick();

        // Restart from PTR=0, all requesters held
        RST = 1'b1; model_reset(); tick(); RST = 1'b0;
        for (int i = 0; i < NR; i++) begin req_addr[i] = AW'(i); req_data[i] = RW'(i + 1); end
        REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk($sformatf("t3_gnt%0d", g), 32'(gnt8), 32'(1) << order[g]);
            tick();
            chk($sformatf("t3_idle%0d", g), 32'(busy8), 32'h0);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("t3_bank%0d", k), 32'(bank8[k]), 32'(k + 1));

        // Pointer wrap: grant 3, then 1001 -> 0 before 3
        REQ = 4'b1000;
        tick(); chk("t4_gnt_a", 32'(gnt8), 32'h8); tick();
        REQ = 4'b1001;
        tick(); chk("t4_gnt_b", 32'(gnt8), 32'h1); tick();
        REQ = 4'b1000;
        tick(); chk("t4_gnt_c", 32'(gnt8), 32'h8); tick();
        REQ = '0;
        tick();

        // Out-of-range address on the 6-register instance
        REQ = 4'b0010; req_addr[1] = 3'd7; req_data[1] = 4'h5;
        tick();
        chk("t5_gnt", 32'(gnt6), 32'h2);
        chk("t5_err", 32'(err6), 32'h1);
        chk("t5_en", 32'(en6), 32'h0);
        tick();
        REQ = '0;
        chk("t5_err_off", 32'(err6), 32'h0);
        tick();
        check_banks();

        // Asynchronous reset in the middle of WRITE
        keep = bank8[1];
        REQ = 4'b0100; req_addr[2] = 3'd1; req_data[2] = ~keep;
        tick();
        chk("t6_busy", 32'(busy8), 32'h1);
        #2 RST = 1'b1;
        model_reset();
        #1;
        chk("t6_gnt", 32'(gnt8), 32'h0);
        chk("t6_en", 32'(en8), 32'h0);
        chk("t6_busy_off", 32'(busy8), 32'h0);
        REQ = '0;
        tick();
        RST = 1'b0;
        tick();
        chk("t6_bank1", 32'(bank8[1]), 32'(keep));
        REQ = 4'b1111;
        tick();
        chk("t6_ptr0", 32'(gnt8), 32'h1);
        tick();
        REQ = '0;
        tick();

        // Random registered requesters
        auto_req = 1'b1;
        repeat (600) tick();
        auto_req = 1'b0;
        REQ = '0;
        repeat (3) tick();
        check_banks();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
